// File: rtl/sync_fifo_wr_arb_pkg.sv
// Shared types and FIFO geometry for the write-side arbiter and the future
// read-side scheduler.
package sync_fifo_wr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int unsigned FIFO_DEPTH = 256;
  localparam int unsigned FIFO_DW    = 32;

endpackage

// File: rtl/sync_fifo_wr_arb_rr_pick.sv
// Combinational rotate-priority picker: first set req bit after index 'last',
// wrapping around; 'last' itself has the lowest priority.
module rr_pick
  import sync_fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    any       = |req;
    grant_idx = last;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin burst arbiter driving the single write port of the 256x32b FIFO
// from NUM_REQ valid/ready producers.
module sync_fifo_wr_arb
  import sync_fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            src_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
  output logic [NUM_REQ-1:0]            src_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_full,
  input  logic                          fifo_alm_full,
  output logic [IDX_W-1:0]              owner_id,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          word_cnt
);

  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      owner, rr_last;
  logic [BW-1:0]         burst_cnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  xfer;
  logic                  burst_last;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req       (src_valid),
    .last      (rr_last),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    src_ready = '0;
    if (state == ST_BURST && !fifo_wr_full) begin
      src_ready[owner] = 1'b1;
    end
  end

  assign xfer         = |(src_valid & src_ready);
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = (state == ST_BURST) ? words[owner] : '0;
  assign burst_last   = (burst_cnt == BW'(MAX_BURST - 1));
  assign busy         = (state == ST_BURST);
  assign owner_id     = owner;

  // A full FIFO only gates ready; a dropped valid ends the burst even when full.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_any && !fifo_alm_full) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (!src_valid[owner] || (xfer && burst_last)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_last   <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_BURST) begin
        owner     <= pick_idx;
        rr_last   <= pick_idx;
        burst_cnt <= '0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (xfer) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Self-checking bench for sync_fifo_wr_arb with a behavioural FIFO and a
// queue-based arbiter model compared every cycle.
module tb_sync_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int CW = 16;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_full;
  logic            fifo_alm_full = 1'b0;
  logic [1:0]      owner_id;
  logic            busy;
  logic [CW-1:0]   word_cnt;

  int checks = 0;
  int errors = 0;

  int            acc [N];
  logic [DW-1:0] q [$];
  int            grant_log [$];
  int            burst_log [$];
  int            rd_cnt = 0;
  int            rd_done = 0;

  bit            m_busy;
  int            m_owner, m_last, m_cnt;
  logic [CW-1:0] m_words;

  sync_fifo_wr_arb #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_full  (fifo_wr_full),
    .fifo_alm_full (fifo_alm_full),
    .owner_id      (owner_id),
    .busy          (busy),
    .word_cnt      (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model and FIFO: inputs applied on negedge, compare 1 ns before posedge,
  // model advances on posedge.
  initial begin
    logic [N-1:0]  e_ready;
    logic          e_en;
    logic [DW-1:0] e_data;
    fifo_wr_full = 1'b0;
    src_data     = '0;
    forever begin
      @(negedge clk);
      fifo_wr_full = (q.size() >= DEPTH);
      for (int i = 0; i < N; i++) src_data[i*DW +: DW] = {8'(i), 24'(acc[i])};
      #4;
      if (!rst_n) begin
        chk("rst_ready", src_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_owner", owner_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_cnt", word_cnt, 0);
        m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_words = '0;
        q.delete(); grant_log.delete(); burst_log.delete();
        for (int i = 0; i < N; i++) acc[i] = 0;
        rd_done = rd_cnt;
      end else begin
        e_ready = '0;
        if (m_busy && !fifo_wr_full) e_ready[m_owner] = 1'b1;
        e_en   = |(src_valid & e_ready);
        e_data = m_busy ? {8'(m_owner), 24'(acc[m_owner])} : '0;
        chk("src_ready", src_ready, e_ready);
        chk("ready_onehot0", $onehot0(src_ready), 1);
        chk("fifo_wr_en", fifo_wr_en, e_en);
        chk("fifo_wr_data", fifo_wr_data, e_data);
        chk("owner_id", owner_id, m_owner);
        chk("busy", busy, m_busy);
        chk("word_cnt", word_cnt, m_words);
        @(posedge clk);
        if (rst_n) begin
          if (rd_done < rd_cnt) begin
            rd_done++;
            if (q.size() > 0) void'(q.pop_front());
          end
          if (!m_busy) begin
            if (|src_valid && !fifo_alm_full) begin
              for (int k = 1; k <= N; k++) begin
                if (src_valid[(m_last + k) % N]) begin
                  m_owner = (m_last + k) % N;
                  break;
                end
              end
              m_last = m_owner;
              grant_log.push_back(m_owner);
              m_busy = 1; m_cnt = 0;
            end
          end else if (!src_valid[m_owner]) begin
            burst_log.push_back(m_cnt);
            m_busy = 0;
          end else if (e_en) begin
            q.push_back(e_data);
            acc[m_owner]++;
            m_cnt++;
            m_words++;
            if (m_cnt == MB) begin
              burst_log.push_back(m_cnt);
              m_busy = 0;
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; src_valid = '0; fifo_alm_full = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input int i, input int n, input int lim);
    int c = 0;
    while (acc[i] < n && c < lim) begin @(negedge clk); c++; end
    chk("wait_acc", acc[i] >= n, 1);
  endtask

  task automatic wait_busy(input logic v, input int lim);
    int c = 0;
    while (busy !== v && c < lim) begin @(negedge clk); c++; end
    chk("wait_busy", busy, v);
  endtask

  task automatic wait_grants(input int n, input int lim);
    int c = 0;
    while (grant_log.size() < n && c < lim) begin @(negedge clk); c++; end
    chk("wait_grants", grant_log.size() >= n, 1);
  endtask

  initial begin
    int bad;
    int exp_g [5];
    exp_g = '{0, 1, 2, 3, 0};
    #200;
    rst_n = 1'b1;

    // 1: single producer, 40 words
    src_valid = 4'b0100;
    wait_acc(2, 40, 200);
    src_valid = '0;
    cyc(3); #3;
    chk("t1_word_cnt", word_cnt, 40);
    chk("t1_nbursts", burst_log.size(), 3);
    if (burst_log.size() == 3) begin
      chk("t1_burst0", burst_log[0], 16);
      chk("t1_burst1", burst_log[1], 16);
      chk("t1_burst2", burst_log[2], 8);
    end
    chk("t1_fifo_size", q.size(), 40);
    bad = 0;
    foreach (q[k]) if (q[k] !== {8'd2, 24'(k)}) bad++;
    chk("t1_fifo_order_bad", bad, 0);

    // 2: all producers valid
    do_reset();
    src_valid = 4'b1111;
    wait_grants(5, 200);
    src_valid = '0;
    cyc(3); #3;
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) chk("t2_grant", grant_log[i], exp_g[i]);
    chk("t2_nbursts", burst_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < burst_log.size()) chk("t2_burst_len", burst_log[i], 16);

    // 3: fill to full, then single reads
    do_reset();
    src_valid = 4'b0010;
    wait_acc(1, 5, 50);
    src_valid = '0;
    cyc(3);
    src_valid = 4'b0010;
    begin
      int c = 0;
      while (q.size() < DEPTH && c < 400) begin @(negedge clk); c++; end
    end
    cyc(8); #3;
    chk("t3_full_cnt", word_cnt, 256);
    chk("t3_full_busy", busy, 1);
    chk("t3_full_ready", src_ready, 0);
    rd_cnt++;
    cyc(6); #3;
    chk("t3_one_more", word_cnt, 257);
    rd_cnt += 4;
    cyc(12); #3;
    chk("t3_four_more", word_cnt, 261);
    chk("t3_nbursts", burst_log.size(), 17);
    if (burst_log.size() > 0) begin
      chk("t3_first_burst", burst_log[0], 5);
      chk("t3_frozen_burst", burst_log[burst_log.size()-1], 16);
    end
    src_valid = '0;

    // 4: almost-full blocks grants but not a running burst
    do_reset();
    fifo_alm_full = 1'b1;
    src_valid = 4'b1000;
    cyc(10); #3;
    chk("t4_alm_busy", busy, 0);
    chk("t4_alm_ready", src_ready, 0);
    chk("t4_alm_cnt", word_cnt, 0);
    fifo_alm_full = 1'b0;
    wait_busy(1'b1, 20);
    wait_acc(3, 3, 20);
    fifo_alm_full = 1'b1;
    wait_busy(1'b0, 40);
    cyc(5); #3;
    chk("t4_burst_len", burst_log.size() > 0 ? burst_log[burst_log.size()-1] : -1, 16);
    chk("t4_cnt", word_cnt, 16);
    chk("t4_idle_again", busy, 0);
    fifo_alm_full = 1'b0;
    src_valid = '0;

    // 5: owner drops valid after 5 words
    do_reset();
    src_valid = 4'b0101;
    wait_acc(0, 5, 50);
    src_valid = 4'b0100;
    @(negedge clk); #3;
    chk("t5_idle", busy, 0);
    @(negedge clk); #3;
    chk("t5_regrant_busy", busy, 1);
    chk("t5_regrant_owner", owner_id, 2);
    wait_grants(2, 10);
    if (grant_log.size() >= 2) begin
      chk("t5_grant0", grant_log[0], 0);
      chk("t5_grant1", grant_log[1], 2);
    end
    if (burst_log.size() >= 1) chk("t5_burst0", burst_log[0], 5);
    src_valid = '0;

    // 6: asynchronous reset mid-burst
    do_reset();
    src_valid = 4'b0010;
    wait_acc(1, 3, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", src_ready, 0);
    chk("t6_wr_en", fifo_wr_en, 0);
    chk("t6_wr_data", fifo_wr_data, 0);
    chk("t6_owner", owner_id, 0);
    chk("t6_cnt", word_cnt, 0);
    @(negedge clk);
    src_valid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    wait_grants(1, 10);
    if (grant_log.size() >= 1) chk("t6_first_grant", grant_log[0], 0);
    src_valid = '0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
